// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types, frame constants and address-bit helper for the ADC128S022 reader
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GUARD
  } state_e;

  localparam int FRAME_BITS     = 16;
  localparam int ADDR_FIRST_BIT = 3;
  localparam int DATA_FIRST_BIT = 5;
  localparam int RESULT_W       = 12;
  localparam int CH_W           = 3;
  localparam int IDX_W          = 5;

  // Address bit driven on SCLK fall k; zero outside the three address slots.
  function automatic logic addr_bit(input logic [CH_W-1:0] addr, input int k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < CH_W; i++) begin
      if (k == ADDR_FIRST_BIT + i) b = addr[CH_W-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/adc128s022_reader_if.sv
// rtl/adc128s022_reader_if.sv - request/result handshake between host logic and the ADC reader
interface adc128s022_reader_if;
  import adc_pkg::*;

  logic                start;
  logic [CH_W-1:0]     ch_sel;
  logic                busy;
  logic                data_valid;
  logic [RESULT_W-1:0] data_out;
  logic [CH_W-1:0]     data_ch;

  modport master (
    output start, ch_sel,
    input  busy, data_valid, data_out, data_ch
  );

  modport slave (
    input  start, ch_sel,
    output busy, data_valid, data_out, data_ch
  );

endinterface

// File: rtl/adc_sck_phase_gen.sv
// rtl/adc_sck_phase_gen.sv - SCLK half-period counter: fall/rise strobes and 1-based bit index
module adc_sck_phase_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             en_i,
  output logic             fall_tick_o,
  output logic             rise_tick_o,
  output logic [IDX_W-1:0] bit_idx_o
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick;

  // half_q=0: currently in a high half, so the next tick is a fall.
  assign tick        = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign fall_tick_o = tick && !half_q;
  assign rise_tick_o = tick && half_q;
  assign bit_idx_o   = fall_tick_o ? idx_q + IDX_W'(1) : idx_q;

  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    idx_d  = idx_q;
    if (!en_i) begin
      cnt_d  = '0;
      half_d = 1'b0;
      idx_d  = '0;
    end else if (tick) begin
      cnt_d  = '0;
      half_d = ~half_q;
      if (!half_q) idx_d = idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/adc128s022_reader.sv
// rtl/adc128s022_reader.sv - ADC128S022 serial master: one 12-bit conversion per accepted request
module adc128s022_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic                      clk_50M,
  input  logic                      rst,
  adc128s022_reader_if.slave        host,
  output logic                      adc_cs_n,
  output logic                      adc_sck,
  output logic                      adc_din,
  input  logic                      adc_dout
);

  state_e              state_q;
  logic                cs_n_q, sck_q, din_q, busy_q, dv_q;
  logic [RESULT_W-1:0] result_q, data_out_q;
  logic [CH_W-1:0]     cur_addr_q, prev_addr_q, data_ch_q;
  logic                fall_tick, rise_tick;
  logic [IDX_W-1:0]    bit_idx;

  adc_sck_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .en_i        (state_q != ST_IDLE),
    .fall_tick_o (fall_tick),
    .rise_tick_o (rise_tick),
    .bit_idx_o   (bit_idx)
  );

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b1;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
      dv_q        <= 1'b0;
      result_q    <= '0;
      data_out_q  <= '0;
      data_ch_q   <= '0;
      cur_addr_q  <= '0;
      prev_addr_q <= '0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (host.start) begin
          cur_addr_q <= host.ch_sel;
          cs_n_q     <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= ST_SETUP;
        end
        ST_SETUP: if (fall_tick) begin
          sck_q   <= 1'b0;
          din_q   <= addr_bit(cur_addr_q, int'(bit_idx));
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (fall_tick) begin
            sck_q <= 1'b0;
            din_q <= addr_bit(cur_addr_q, int'(bit_idx));
          end else if (rise_tick) begin
            sck_q <= 1'b1;
            if (int'(bit_idx) >= DATA_FIRST_BIT) result_q <= {result_q[RESULT_W-2:0], adc_dout};
            if (int'(bit_idx) == FRAME_BITS) state_q <= ST_HOLD;
          end
        end
        // The ADC converts the channel addressed in the previous frame.
        ST_HOLD: if (fall_tick) begin
          cs_n_q      <= 1'b1;
          dv_q        <= 1'b1;
          data_out_q  <= result_q;
          data_ch_q   <= prev_addr_q;
          prev_addr_q <= cur_addr_q;
          state_q     <= ST_GUARD;
        end
        ST_GUARD: if (rise_tick) begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign adc_cs_n        = cs_n_q;
  assign adc_sck         = sck_q;
  assign adc_din         = din_q;
  assign host.busy       = busy_q;
  assign host.data_valid = dv_q;
  assign host.data_out   = data_out_q;
  assign host.data_ch    = data_ch_q;

endmodule

// File: doc/adc128s022_reader.md
# adc128s022_reader

Serial-interface master that reads one 12-bit conversion from the ADC128S022 per request, entirely in the clk_50M domain. It generates the 3.125 MHz ADC serial clock internally as a phase counter, not a derived clock. It drives CS_N/SCLK/DIN, captures DOUT, and returns the result with its channel tag to the line-sensing and CPU logic.

## Interface
- CLK_DIV, 8: clk_50M cycles per SCLK half-period (8 gives 3.125 MHz); legal range ≥ 2.
- clk_50M  input  1  50 MHz system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only when busy = 0.
- ch_sel  input  3  channel to address in this frame; sampled only on acceptance.
- busy  output  1  high from the cycle after acceptance until the frame and CS-high guard complete.
- data_valid  output  1  one-cycle pulse: data_out/data_ch updated.
- data_out  output  12  conversion result, MSB first from ADC; held until next data_valid.
- data_ch  output  3  channel that data_out belongs to.
- adc_cs_n  output  1  ADC chip select, active low.
- adc_sck  output  1  ADC serial clock; idles high.
- adc_din  output  1  ADC address input.
- adc_dout  input  1  ADC serial data output.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → GUARD → IDLE.
- IDLE: cs_n=1, sck=1, din=0. On start: latch ch_sel into cur_addr and go to SETUP.
- SETUP: cs_n=0 for CLK_DIV cycles, sck high.
- SHIFT: 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV high; bit index k = 1..16.
- Falling edge k: din = cur_addr[2] at k=3, [1] at k=4, [0] at k=5, else 0.
- Rising edge k: for k = 5..16, shift adc_dout into the result register, giving D11..D0.
- HOLD: sck high for CLK_DIV cycles, then cs_n=1 and enter GUARD.
- Entering GUARD: data_out ← result, data_ch ← prev_addr, prev_addr ← cur_addr, and data_valid pulses.
- Reason for data_ch ← prev_addr: the ADC converts the channel addressed in the previous frame.
- GUARD: cs_n=1 for CLK_DIV cycles, then IDLE with busy=0.
- prev_addr resets to 0, matching the ADC power-up address.
- start while busy is ignored, not queued. start and rst in the same cycle: rst wins.
- Reset, including mid-frame, sets:
  - cs_n=1, sck=1, din=0, busy=0, data_valid=0;
  - data_out=0, data_ch=0, prev_addr=0;
  - state IDLE, counters 0.
  - A frame aborted by reset produces no data_valid.

## Timing
- Reference point: cycle 0 is the rising edge that samples start=1 with busy=0.
- Cycle 1: cs_n=0, busy=1.
- SCLK fall k at cycle 1+CLK_DIV+(2k-2)·CLK_DIV; rise k at fall k + CLK_DIV.
- CLK_DIV=8: first fall 9, first rise 17, 16th rise 257.
- adc_dout is sampled on the clk_50M edge that drives sck high; it has been stable ≥ CLK_DIV cycles.
- adc_din changes only on the edge that drives sck low.
- cs_n rises and data_valid pulses at cycle 1+33·CLK_DIV (265).
- busy falls at cycle 1+34·CLK_DIV (273); the earliest next acceptance is that same cycle.
- Throughput: one conversion per 34·CLK_DIV+1 cycles back-to-back.
- Outputs are registered; no combinational path from adc_dout or start to any output.

## Structure
- Shared package adc_pkg holds:
  - state enum;
  - FRAME_BITS=16, ADDR_FIRST_BIT=3, DATA_FIRST_BIT=5, RESULT_W=12, CH_W=3.
- One sub-module, adc_sck_phase_gen: half-period counter that emits fall_tick/rise_tick strobes and the 1..16 bit index, enabled by the FSM. The FSM, shift registers and output registers stay in the top.

## Test plan
- Bench ADC model returns value 0x0A5 + 0x100·addr for the channel addressed in the prior frame.
- Single read after reset, ch_sel=5 → data_valid at cycle 265, data_ch=0, data_out=0x0A5; din carries 1,0,1 at falls 3–5.
- Back-to-back reads ch 5 then ch 2:
  - second data_valid gives data_ch=5, data_out=0x5A5;
  - second acceptance at cycle 273 exactly.
- start pulsed at cycles 10, 100 and 264 during a frame → ignored; exactly one data_valid; ch_sel changes mid-frame have no effect.
- rst at cycle 150 mid-SHIFT → next edge cs_n=1, sck=1, busy=0, data_out=0; no data_valid; the next read reports data_ch=0.
- CLK_DIV=2 build, read ch 7 → SCLK period 4 cycles; data_valid at cycle 67; din 1,1,1 at falls 3–5.
- Protocol checker throughout:
  - exactly 16 SCLK falls per CS-low window;
  - sck high whenever cs_n toggles;
  - cs_n high ≥ CLK_DIV cycles between frames.
